// File: rtl/piso_serial_tx_if.sv
// ---------------------------------------------------------------------------
// piso_serial_tx_if
//   Handshake and line bundle between a word producer and piso_serial_tx.
//
//   Handshake rule: a word moves when valid=1 and ready=1 at the same rising
//   clock edge. The producer may raise valid at any time. The transmitter only
//   raises ready while idle. din is sampled only at that edge.
//
//   Signals
//     din    producer -> tx   WIDTH  parallel word
//     valid  producer -> tx   1      din is offered
//     ready  tx -> producer   1      transmitter idle, able to accept
//     sout   tx -> line       1      serial line, idles high
//     busy   tx -> observer   1      frame in progress (always ~ready)
//     done   tx -> observer   1      one-cycle pulse when a frame completes
//
//   Modports
//     master : the word producer / line observer
//     slave  : the transmitter
// ---------------------------------------------------------------------------
interface piso_serial_tx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             valid;
    logic             ready;
    logic             sout;
    logic             busy;
    logic             done;

    modport master (
        output din,
        output valid,
        input  ready,
        input  sout,
        input  busy,
        input  done
    );

    modport slave (
        input  din,
        input  valid,
        output ready,
        output sout,
        output busy,
        output done
    );
endinterface

// File: rtl/piso_serial_tx.sv
// ---------------------------------------------------------------------------
// piso_serial_tx
//   Parallel-in / serial-out frame transmitter. A WIDTH-bit word accepted on
//   the valid/ready handshake of the bus interface is sent as
//       start bit (0), data LSB first, [even parity], stop bit (1)
//   with every bit held on sout for DIV clock cycles. The line idles high.
//
//   Optional feature macro: PISO_TX_PARITY_EN
//     defined   : a PARITY bit (XOR of the latched word) is sent between the
//                 last data bit and the stop bit.
//     undefined : DATA goes straight to STOP.
//
//   Parameters
//     WIDTH  data bits per frame (>=1)
//     DIV    clock cycles per serial bit (>=1)
//
//   Ports
//     clk        in   1      rising-edge clock
//     rst        in   1      asynchronous, active-low reset
//     bus        slave modport of piso_serial_tx_if (din/valid/ready/
//                sout/busy/done)
//     dbg_state  out  3      current FSM state encoding, for observation
//
//   All outputs come straight from flops. The next-state process computes
//   the next value of every register, including the outputs, so sout/ready/
//   busy/done change exactly on the edge where the state changes.
// ---------------------------------------------------------------------------
module piso_serial_tx #(
    parameter int WIDTH = 8,
    parameter int DIV   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    piso_serial_tx_if.slave      bus,
    output logic [2:0]           dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // Counter widths stay at least one bit so DIV=1 / WIDTH=1 remain legal.
    localparam int DCW = (DIV   > 1) ? $clog2(DIV)   : 1;
    localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV - 1);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);

    state_t           state_q, state_n;
    logic [DCW-1:0]   div_q,   div_n;
    logic [BCW-1:0]   bit_q,   bit_n;
    logic [WIDTH-1:0] sh_q,    sh_n;
    logic             sout_q,  sout_n;
    logic             ready_q, ready_n;
    logic             busy_q,  busy_n;
    logic             done_q,  done_n;

`ifdef PISO_TX_PARITY_EN
    logic             par_q,   par_n;
`endif

    // Last cycle of the current bit period.
    logic             bit_end;
    logic [WIDTH-1:0] sh_shifted;

    assign bit_end    = (div_q == DIV_LAST);
    assign sh_shifted = sh_q >> 1;

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            sout_q  <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef PISO_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_n;
            div_q   <= div_n;
            bit_q   <= bit_n;
            sh_q    <= sh_n;
            sout_q  <= sout_n;
            ready_q <= ready_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
`ifdef PISO_TX_PARITY_EN
            par_q   <= par_n;
`endif
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and next-output logic
    //   sout_n is the value for the bit period that begins at the next edge,
    //   so at each period boundary it is loaded with the upcoming bit.
    // -----------------------------------------------------------------------
    always_comb begin
        state_n = state_q;
        div_n   = div_q;
        bit_n   = bit_q;
        sh_n    = sh_q;
        sout_n  = sout_q;
        done_n  = 1'b0;
`ifdef PISO_TX_PARITY_EN
        par_n   = par_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                sout_n = 1'b1;
                if (bus.valid && ready_q) begin
                    sh_n    = bus.din;
`ifdef PISO_TX_PARITY_EN
                    par_n   = ^bus.din;
`endif
                    div_n   = '0;
                    bit_n   = '0;
                    sout_n  = 1'b0;
                    state_n = S_START;
                end
            end

            S_START: begin
                if (bit_end) begin
                    div_n   = '0;
                    sout_n  = sh_q[0];
                    state_n = S_DATA;
                end else begin
                    div_n = div_q + DCW'(1);
                end
            end

            S_DATA: begin
                if (bit_end) begin
                    div_n = '0;
                    sh_n  = sh_shifted;
                    if (bit_q == BIT_LAST) begin
                        bit_n   = '0;
`ifdef PISO_TX_PARITY_EN
                        sout_n  = par_q;
                        state_n = S_PARITY;
`else
                        sout_n  = 1'b1;
                        state_n = S_STOP;
`endif
                    end else begin
                        bit_n  = bit_q + BCW'(1);
                        sout_n = sh_shifted[0];
                    end
                end else begin
                    div_n = div_q + DCW'(1);
                end
            end

`ifdef PISO_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    div_n   = '0;
                    sout_n  = 1'b1;
                    state_n = S_STOP;
                end else begin
                    div_n = div_q + DCW'(1);
                end
            end
`endif

            S_STOP: begin
                if (bit_end) begin
                    div_n   = '0;
                    sout_n  = 1'b1;
                    done_n  = 1'b1;
                    state_n = S_IDLE;
                end else begin
                    div_n = div_q + DCW'(1);
                end
            end

            default: begin
                // Unreachable encodings fall back to a clean idle line.
                div_n   = '0;
                bit_n   = '0;
                sout_n  = 1'b1;
                state_n = S_IDLE;
            end
        endcase

        // ready/busy are registered decodes of the next state, keeping
        // busy == ~ready and done only ever asserted with ready.
        ready_n = (state_n == S_IDLE);
        busy_n  = ~ready_n;
    end

    assign bus.sout  = sout_q;
    assign bus.ready = ready_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_piso_serial_tx.sv
// ---------------------------------------------------------------------------
// tb_piso_serial_tx
//   Three transmitters share clk/rst:
//     sel 0 : WIDTH=8, DIV=4
//     sel 1 : WIDTH=8, DIV=1
//     sel 2 : WIDTH=1, DIV=2
//   Inputs change and outputs are sampled on the falling edge. Expected line
//   waveforms come from a frame model that lists the frame bits and repeats
//   each one DIV times into exp_q.
// ---------------------------------------------------------------------------
module tb_piso_serial_tx;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    piso_serial_tx_if #(.WIDTH(8)) ifa ();
    piso_serial_tx_if #(.WIDTH(8)) ifb ();
    piso_serial_tx_if #(.WIDTH(1)) ifc ();

    logic [2:0] dbg_a, dbg_b, dbg_c;

    piso_serial_tx #(.WIDTH(8), .DIV(4)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave), .dbg_state(dbg_a));
    piso_serial_tx #(.WIDTH(8), .DIV(1)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave), .dbg_state(dbg_b));
    piso_serial_tx #(.WIDTH(1), .DIV(2)) dut_c (.clk(clk), .rst(rst), .bus(ifc.slave), .dbg_state(dbg_c));

    int width_of [3] = '{8, 8, 1};
    int div_of   [3] = '{4, 1, 2};

`ifdef PISO_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    // ---------------- scoreboard ----------------
    logic [0:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame model: start 0, data LSB first, optional even parity, stop 1,
    // every bit repeated DIV times.
    function automatic void build_exp(input int sel, input logic [7:0] w);
        logic       bits[$];
        logic       par;
        par = 1'b0;
        bits.push_back(1'b0);
        for (int i = 0; i < width_of[sel]; i++) begin
            bits.push_back(w[i]);
            par = par ^ w[i];
        end
        if (P == 1) bits.push_back(par);
        bits.push_back(1'b1);
        exp_q.delete();
        foreach (bits[i])
            for (int r = 0; r < div_of[sel]; r++) exp_q.push_back(bits[i]);
    endfunction

    // ---------------- driver / sampler tasks ----------------
    task automatic drive(input int sel, input logic v, input logic [7:0] d);
        case (sel)
            0: begin ifa.valid = v; ifa.din = d; end
            1: begin ifb.valid = v; ifb.din = d; end
            default: begin ifc.valid = v; ifc.din = d[0]; end
        endcase
    endtask

    task automatic sample(input int sel, output logic so, output logic rd, output logic bz, output logic dn);
        case (sel)
            0: begin so = ifa.sout; rd = ifa.ready; bz = ifa.busy; dn = ifa.done; end
            1: begin so = ifb.sout; rd = ifb.ready; bz = ifb.busy; dn = ifb.done; end
            default: begin so = ifc.sout; rd = ifc.ready; bz = ifc.busy; dn = ifc.done; end
        endcase
    endtask

    // Called on a falling edge while the DUT is idle; returns on the falling
    // edge of the first frame cycle (start bit).
    task automatic start_frame(input int sel, input logic [7:0] w);
        logic so, rd, bz, dn;
        sample(sel, so, rd, bz, dn);
        chk("pre_ready", {31'd0, rd}, 32'd1);
        drive(sel, 1'b1, w);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Checks every cycle of the frame for w, then the done cycle. With keep=1
    // valid stays high carrying nw so it is accepted at the end of done.
    // pulse_cyc >= 0 raises valid with din=FF for one cycle mid-frame.
    task automatic check_body(input int sel, input logic [7:0] w, input logic keep,
                              input logic [7:0] nw, input int pulse_cyc);
        logic so, rd, bz, dn;
        logic [0:0] e;
        int n;
        build_exp(sel, w);
        n = exp_q.size();
        chk("frame_len", n, (width_of[sel] + 2 + P) * div_of[sel]);
        if (keep) drive(sel, 1'b1, nw);
        else      drive(sel, 1'b0, 8'($urandom));
        for (int k = 0; k < n; k++) begin
            if (pulse_cyc >= 0 && k == pulse_cyc)          drive(sel, 1'b1, 8'hFF);
            else if (pulse_cyc >= 0 && k == pulse_cyc + 1) drive(sel, 1'b0, 8'($urandom));
            sample(sel, so, rd, bz, dn);
            e = exp_q.pop_front();
            chk("sout",       {31'd0, so}, {31'd0, e});
            chk("busy_frame", {31'd0, bz}, 32'd1);
            chk("ready_frame",{31'd0, rd}, 32'd0);
            chk("done_frame", {31'd0, dn}, 32'd0);
            @(negedge clk);
        end
        sample(sel, so, rd, bz, dn);
        chk("done_pulse", {31'd0, dn}, 32'd1);
        chk("done_ready", {31'd0, rd}, 32'd1);
        chk("done_busy",  {31'd0, bz}, 32'd0);
        chk("done_sout",  {31'd0, so}, 32'd1);
    endtask

    // After the done cycle with no follow-on word: line idle, pulse gone.
    task automatic idle_after(input int sel);
        logic so, rd, bz, dn;
        drive(sel, 1'b0, 8'($urandom));
        @(negedge clk);
        sample(sel, so, rd, bz, dn);
        chk("idle_done",  {31'd0, dn}, 32'd0);
        chk("idle_ready", {31'd0, rd}, 32'd1);
        chk("idle_sout",  {31'd0, so}, 32'd1);
    endtask

    task automatic check_reset_state(input int sel, input string tag);
        logic so, rd, bz, dn;
        sample(sel, so, rd, bz, dn);
        chk({tag, "_sout"},  {31'd0, so}, 32'd1);
        chk({tag, "_ready"}, {31'd0, rd}, 32'd1);
        chk({tag, "_busy"},  {31'd0, bz}, 32'd0);
        chk({tag, "_done"},  {31'd0, dn}, 32'd0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic so, rd, bz, dn;
        logic [7:0] w;
        int sel;

        rst = 1'b0;
        drive(0, 1'b0, 8'h00);
        drive(1, 1'b0, 8'h00);
        drive(2, 1'b0, 8'h00);
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) check_reset_state(s, "reset");
        rst = 1'b1;
        @(negedge clk);

        // Single word A5, then 07 (parity 1 when enabled).
        start_frame(0, 8'hA5); check_body(0, 8'hA5, 1'b0, 8'h00, -1); idle_after(0);
        start_frame(0, 8'h07); check_body(0, 8'h07, 1'b0, 8'h00, -1); idle_after(0);

        // Back-to-back 3C then C3 with valid held high.
        start_frame(0, 8'h3C);
        check_body(0, 8'h3C, 1'b1, 8'hC3, -1);
        @(negedge clk);
        check_body(0, 8'hC3, 1'b0, 8'h00, -1);
        idle_after(0);

        // valid pulse with FF mid-frame of 00 must be ignored.
        start_frame(0, 8'h00); check_body(0, 8'h00, 1'b0, 8'h00, 10); idle_after(0);

        // Reset during DATA bit 3 of a frame.
        start_frame(0, 8'h96);
        drive(0, 1'b0, 8'h00);
        repeat (17) @(negedge clk);
        sample(0, so, rd, bz, dn);
        chk("pre_rst_bit3", {31'd0, so}, 32'd0); // 8'h96 bit 3 = 0
        chk("pre_rst_busy", {31'd0, bz}, 32'd1);
        #1 rst = 1'b0;
        #1 check_reset_state(0, "rst_mid");
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_reset_state(0, "post_rst");
        end
        start_frame(0, 8'h5A); check_body(0, 8'h5A, 1'b0, 8'h00, -1); idle_after(0);

        // DIV=1 word 81.
        start_frame(1, 8'h81); check_body(1, 8'h81, 1'b0, 8'h00, -1); idle_after(1);

        // WIDTH=1 both values.
        start_frame(2, 8'h01); check_body(2, 8'h01, 1'b0, 8'h00, -1); idle_after(2);
        start_frame(2, 8'h00); check_body(2, 8'h00, 1'b0, 8'h00, -1); idle_after(2);

        // Random words on random instances, random idle gaps.
        for (int i = 0; i < 15; i++) begin
            sel = int'($urandom_range(0, 2));
            w   = 8'($urandom);
            start_frame(sel, w);
            check_body(sel, w, 1'b0, 8'h00, -1);
            idle_after(sel);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
